// File: rtl/multiplier_result_accumulator.sv
// Accumulates SIMD multiplier result beats into a dot-product job result.
// Ports: clk/reset, in_* beat handshake + result words, out_* job result handshake.
module multiplier_result_accumulator #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      result_0,
  input  logic [31:0]      result_1,
  input  logic [7:0]       result_SIDM_carry,
  input  logic [1:0]       mode,
  input  logic             signed_en,
  input  logic [LEN_W-1:0] length,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_carry,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic             sgn_q;
  logic [LEN_W-1:0] cnt;
  logic [1:0]       dcnt;
  logic             s1_val;
  logic [ACC_W-1:0] s1_v;
  logic [ACC_W-1:0] acc;
  logic             carry_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic             xfer;
  logic [1:0]       eff_mode;
  logic             eff_sgn;
  logic [31:0]      w32;
  logic [15:0]      lo16;
  logic [15:0]      hi16;
  logic [ACC_W-1:0] v_dec;
  logic [ACC_W:0]   sum;
  logic             ovf_now;
  logic             seg_cy;

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign xfer      = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_acc   = acc;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;

  // The first beat of a job decodes with the live job fields,
  // later beats with the values latched on that first beat.
  always_comb begin
    eff_mode = mode_q;
    eff_sgn  = sgn_q;
    if (state == IDLE) begin
      eff_mode = mode;
      eff_sgn  = signed_en;
    end
  end

  always_comb begin
    w32  = result_0 + result_1;
    lo16 = result_0[15:0] + result_1[15:0];
    hi16 = result_0[31:16] + result_1[31:16];
    if (eff_mode == 2'b00) begin
      v_dec = {{(ACC_W-32){eff_sgn & w32[31]}}, w32};
    end else begin
      v_dec = {{(ACC_W-16){eff_sgn & lo16[15]}}, lo16}
            + {{(ACC_W-16){eff_sgn & hi16[15]}}, hi16};
    end
  end

  assign seg_cy = (eff_mode != 2'b00) && (|result_SIDM_carry);

  assign sum = {1'b0, acc} + {1'b0, s1_v};

  // Signed overflow: like-signed operands giving a differently signed sum.
  always_comb begin
    if (sgn_q) begin
      ovf_now = (acc[ACC_W-1] == s1_v[ACC_W-1])
             && (sum[ACC_W-1] != acc[ACC_W-1]);
    end else begin
      ovf_now = sum[ACC_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= 2'b00;
      sgn_q       <= 1'b0;
      cnt         <= '0;
      dcnt        <= 2'd0;
      s1_val      <= 1'b0;
      s1_v        <= '0;
      acc         <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_val <= xfer;
      if (xfer) begin
        s1_v <= v_dec;
      end

      if (xfer && (state == IDLE)) begin
        acc     <= '0;
        ovf_q   <= 1'b0;
        carry_q <= seg_cy;
      end else begin
        if (s1_val) begin
          acc   <= sum[ACC_W-1:0];
          ovf_q <= ovf_q | ovf_now;
        end
        if (xfer) begin
          carry_q <= carry_q | seg_cy;
        end
      end

      unique case (state)
        IDLE: begin
          if (xfer) begin
            mode_q <= mode;
            sgn_q  <= signed_en;
            dcnt   <= 2'd0;
            if (length == '0) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              // The IDLE beat itself counts as one of the length+1 beats.
              cnt   <= length - LEN_W'(1);
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (xfer) begin
            if (cnt == '0) begin
              dcnt  <= 2'd0;
              state <= DRAIN;
            end else begin
              cnt <= cnt - LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (dcnt == 2'd2) begin
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end else begin
            dcnt <= dcnt + 2'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_result_accumulator.sv
// Randomized self-checking bench for multiplier_result_accumulator.
// Two instances (ACC_W=40 and ACC_W=34) share stimulus and one job model.
module tb_multiplier_result_accumulator;

  logic        clk = 0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready34;
  logic [31:0] result_0;
  logic [31:0] result_1;
  logic [7:0]  cy_in;
  logic [1:0]  mode;
  logic        signed_en;
  logic [7:0]  length;
  logic        out_ready;
  logic        out_valid;
  logic [39:0] out_acc;
  logic        out_carry;
  logic        out_ovf;
  logic        ov34;
  logic [33:0] acc34;
  logic        cy34;
  logic        of34;

  int pass_cnt = 0;
  int total = 0;

  bit [31:0] q0[$];
  bit [31:0] q1[$];
  bit [7:0]  qc[$];

  always #5 clk = ~clk;

  multiplier_result_accumulator #(.ACC_W(40), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .result_0(result_0), .result_1(result_1),
    .result_SIDM_carry(cy_in), .mode(mode), .signed_en(signed_en),
    .length(length), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_carry(out_carry), .out_ovf(out_ovf)
  );

  multiplier_result_accumulator #(.ACC_W(34), .LEN_W(8)) dut34 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready34),
    .result_0(result_0), .result_1(result_1),
    .result_SIDM_carry(cy_in), .mode(mode), .signed_en(signed_en),
    .length(length), .out_valid(ov34), .out_ready(out_ready),
    .out_acc(acc34), .out_carry(cy34), .out_ovf(of34)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Job-level reference: sum every beat's value as an integer and
  // judge overflow against the representable range of a w-bit acc.
  task automatic model(input int w, input bit [1:0] m, input bit s,
                       output longint unsigned acc, output bit ovf,
                       output bit cy);
    longint unsigned mask;
    longint v, sa, t, lo, hi, mx, mn;
    bit [31:0] w32;
    bit [15:0] l16, h16;
    mask = (64'd1 << w) - 1;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    acc = 0; ovf = 0; cy = 0;
    for (int i = 0; i < q0.size(); i++) begin
      if (m == 2'b00) begin
        w32 = q0[i] + q1[i];
        v = s ? longint'($signed(w32)) : longint'(w32);
      end else begin
        l16 = q0[i][15:0] + q1[i][15:0];
        h16 = q0[i][31:16] + q1[i][31:16];
        lo = s ? longint'($signed(l16)) : longint'(l16);
        hi = s ? longint'($signed(h16)) : longint'(h16);
        v = lo + hi;
        cy |= (qc[i] != 0);
      end
      if (s) begin
        sa = acc[w-1] ? longint'(acc) - (longint'(1) << w) : longint'(acc);
        t = sa + v;
        if (t > mx || t < mn) ovf = 1;
      end else begin
        if (acc + (longint'(v) & mask) > mask) ovf = 1;
      end
      acc = (acc + longint'(v)) & mask;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input bit [1:0] m, input bit s,
                      input bit first);
    int n = 0;
    result_0 = q0[i];
    result_1 = q1[i];
    cy_in = qc[i];
    if (first) begin
      mode = m;
      signed_en = s;
      length = 8'(q0.size() - 1);
    end else begin
      mode = 2'($urandom);
      signed_en = 1'($urandom);
      length = 8'($urandom);
    end
    in_valid = 1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic run_job(input bit [1:0] m, input bit s, input bit gaps,
                         input int stall);
    longint unsigned e40, e34;
    bit o40, o34, c40, c34;
    int n;
    logic [39:0] held;
    model(40, m, s, e40, o40, c40);
    model(34, m, s, e34, o34, c34);
    for (int i = 0; i < q0.size(); i++) begin
      send(i, m, s, i == 0);
      if (gaps && i != q0.size() - 1)
        repeat ($urandom_range(0, 2)) tick();
    end
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'd3);
    chk("acc40", 64'(out_acc), e40);
    chk("ovf40", 64'(out_ovf), 64'(o40));
    chk("carry40", 64'(out_carry), 64'(c40));
    chk("acc34", 64'(acc34), e34);
    chk("ovf34", 64'(of34), 64'(o34));
    chk("carry34", 64'(cy34), 64'(c34));
    held = out_acc;
    in_valid = 1;
    length = 0;
    repeat (stall) tick();
    chk("hold_ready", 64'(in_ready), 64'd0);
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_acc", 64'(out_acc), 64'(held));
    out_ready = 1;
    tick();
    out_ready = 0;
    in_valid = 0;
    chk("rel_valid", 64'(out_valid), 64'd0);
    chk("rel_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic clr();
    q0.delete();
    q1.delete();
    qc.delete();
  endtask

  task automatic push(input bit [31:0] a, input bit [31:0] b,
                      input bit [7:0] c);
    q0.push_back(a);
    q1.push_back(b);
    qc.push_back(c);
  endtask

  initial begin
    reset = 1;
    in_valid = 0;
    result_0 = 0;
    result_1 = 0;
    cy_in = 0;
    mode = 0;
    signed_en = 0;
    length = 0;
    out_ready = 0;
    #2;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_acc", 64'(out_acc), 64'd0);
    chk("rst_carry", 64'(out_carry), 64'd0);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    tick();
    tick();
    reset = 0;
    tick();

    clr();
    push(32'h0000_FF00, 32'h0000_0100, 8'h00);
    run_job(2'b00, 0, 0, 2);
    chk("d035_acc", 64'(out_acc), 64'h10000);

    clr();
    repeat (4) push(32'hFFFF_FFFF, 32'h0, 8'h00);
    run_job(2'b01, 1, 0, 10);
    chk("d036_acc", 64'(out_acc), 64'hFF_FFFF_FFF8);

    clr();
    push(32'h1234_5678, 32'h1111_1111, 8'h04);
    push(32'h0000_0001, 32'h0000_0002, 8'h00);
    run_job(2'b11, 0, 0, 1);
    chk("d037_cy_simd", 64'(out_carry), 64'd1);
    run_job(2'b00, 0, 0, 1);
    chk("d037_cy_m00", 64'(out_carry), 64'd0);

    clr();
    repeat (5) push(32'hFFFF_FFFF, 32'h0, 8'h00);
    run_job(2'b00, 0, 1, 3);
    chk("d038_ovf34", 64'(of34), 64'd1);

    clr();
    for (int i = 0; i < 5; i++)
      push($urandom | 32'h100, $urandom, 8'h0);
    send(0, 2'b00, 0, 1);
    send(1, 2'b00, 0, 0);
    tick();
    tick();
    #3;
    reset = 1;
    #1;
    chk("rst_mid_acc", 64'(out_acc), 64'd0);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_ovf", 64'(out_ovf), 64'd0);
    tick();
    reset = 0;
    tick();
    void'(q0.pop_front());
    void'(q1.pop_front());
    void'(qc.pop_front());
    void'(q0.pop_front());
    void'(q1.pop_front());
    void'(qc.pop_front());
    run_job(2'b00, 0, 0, 0);

    for (int j = 0; j < 40; j++) begin
      int nb;
      clr();
      nb = $urandom_range(1, 9);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 3) == 0)
          push(32'hFFFF_FFFF, 32'h8000_0000 | $urandom, 8'($urandom));
        else
          push($urandom, $urandom, ($urandom_range(0, 2) == 0) ?
               8'($urandom) : 8'h0);
      end
      run_job(2'($urandom), 1'($urandom), 1, $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
